// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
//   state_t         : loader phases
//   INSTR_W         : machine-code word width
//   TIMEOUT_DEFAULT : default run timeout (used only with LOADER_TIMEOUT_EN)
package prog_loader_pkg;

  localparam int unsigned INSTR_W         = 9;
  localparam int unsigned TIMEOUT_DEFAULT = 1000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    RUN,
    FIN
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
//   clk, reset : clock, async active-high reset
//   clr        : zero the count
//   en         : count up by one unless already all-ones
//   count      : current value
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot/launch controller for the 9-bit CPU: streams a program into
// instruction memory from address 0, releases the CPU via cpu_start,
// then waits for cpu_done and reports the run length.
// Optional build macro LOADER_TIMEOUT_EN adds parameter TIMEOUT: a run
// reaching TIMEOUT cycles without cpu_done sets err and ends in FIN.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   go                         : level, permits a load from IDLE / leaves FIN when low
//   in_valid/in_data/in_last   : program word stream, in_ready accepts
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
//   cpu_start / cpu_done       : CPU start (held high = parked) and done
//   busy, finished, err        : status (err is sticky until reset)
//   word_count                 : words written by the last load
//   run_cycles                 : cycles spent in RUN, saturating
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned D         = 12,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned START_CYC = 2,
  parameter int unsigned CW        = 16
`ifdef LOADER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               imem_we,
  output logic [D-1:0]       imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_start,
  input  logic               cpu_done,
  output logic               busy,
  output logic               finished,
  output logic               err,
  output logic [D:0]         word_count,
  output logic [CW-1:0]      run_cycles
);

  localparam int unsigned WCW = D + 1;
  localparam int unsigned LW  = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  state_t        state;
  logic [D-1:0]  ptr;
  logic [LW-1:0] lcnt;
  logic          done_q;

  logic xfer_c;
  logic at_limit_c;
  logic launch_end_c;
  logic run_en_c;
  logic timeout_c;

  assign xfer_c       = in_valid & in_ready;
  // This transfer fills the last memory word.
  assign at_limit_c   = (word_count == WCW'(DEPTH - 1));
  assign launch_end_c = (state == LAUNCH) && (lcnt == LW'(START_CYC - 1));
  assign run_en_c     = (state == RUN);

`ifdef LOADER_TIMEOUT_EN
  // This RUN cycle brings run_cycles up to TIMEOUT.
  assign timeout_c = (run_cycles >= CW'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // run_cycles restarts on RUN entry and freezes once RUN is left.
  sat_counter #(.W(CW)) u_run_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (launch_end_c),
    .en    (run_en_c),
    .count (run_cycles)
  );

  // Control FSM; all outputs registered alongside the state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_start  <= 1'b1;
      busy       <= 1'b0;
      finished   <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
      ptr        <= '0;
      lcnt       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= cpu_done;
      imem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state      <= LOAD;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            ptr        <= '0;
            word_count <= '0;
          end
        end
        LOAD: begin
          if (xfer_c) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= in_data;
            ptr        <= ptr + D'(1);
            word_count <= word_count + WCW'(1);
            // A last word that exactly fills memory is still a legal program.
            if (in_last) begin
              state    <= LAUNCH;
              in_ready <= 1'b0;
              lcnt     <= '0;
            end else if (at_limit_c) begin
              state    <= FIN;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              finished <= 1'b1;
              err      <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (launch_end_c) begin
            state     <= RUN;
            cpu_start <= 1'b0;
          end else begin
            lcnt <= lcnt + LW'(1);
          end
        end
        RUN: begin
          if (done_q || timeout_c) begin
            state     <= FIN;
            cpu_start <= 1'b1;
            busy      <= 1'b0;
            finished  <= 1'b1;
            if (!done_q) begin
              err <= 1'b1;
            end
          end
        end
        FIN: begin
          if (!go) begin
            state    <= IDLE;
            finished <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader against a phase-level reference model.
module tb_prog_loader;

  localparam int unsigned D         = 12;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned START_CYC = 2;
  localparam int unsigned CW        = 6;
  localparam int          RUN_MAX   = (1 << CW) - 1;
`ifdef LOADER_TIMEOUT_EN
  localparam int          TMO       = 20;
`endif

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_LAUNCH = 2, PH_RUN = 3, PH_FIN = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0;
  logic          in_valid = 1'b0;
  logic [8:0]    in_data = '0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [D-1:0]  imem_addr;
  logic [8:0]    imem_wdata;
  logic          cpu_start;
  logic          cpu_done = 1'b0;
  logic          busy;
  logic          finished;
  logic          err;
  logic [D:0]    word_count;
  logic [CW-1:0] run_cycles;

  prog_loader #(
    .D(D), .DEPTH(DEPTH), .START_CYC(START_CYC), .CW(CW)
`ifdef LOADER_TIMEOUT_EN
    , .TIMEOUT(TMO)
`endif
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_start(cpu_start), .cpu_done(cpu_done),
    .busy(busy), .finished(finished), .err(err),
    .word_count(word_count), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model: phase, counters and last write, in plain integers.
  int m_phase = PH_IDLE, m_ptr = 0, m_wc = 0, m_left = 0, m_run = 0;
  int m_err = 0, m_we = 0, m_addr = 0, m_wdata = 0, m_done_q = 0;

  always @(posedge clk or posedge reset) begin : model
    int prev;
    if (reset) begin
      m_phase = PH_IDLE; m_ptr = 0; m_wc = 0; m_left = 0; m_run = 0;
      m_err = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_done_q = 0;
    end else begin
      prev     = m_done_q;
      m_done_q = int'(cpu_done);
      m_we     = 0;
      case (m_phase)
        PH_IDLE: if (go) begin m_phase = PH_LOAD; m_ptr = 0; m_wc = 0; end
        PH_LOAD: if (in_valid) begin
          m_we = 1; m_addr = m_ptr; m_wdata = int'(in_data);
          m_ptr++; m_wc++;
          if (in_last) begin m_phase = PH_LAUNCH; m_left = START_CYC; end
          else if (m_wc == DEPTH) begin m_err = 1; m_phase = PH_FIN; end
        end
        PH_LAUNCH: begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_RUN; m_run = 0; end
        end
        PH_RUN: begin
          if (m_run < RUN_MAX) m_run++;
          if (prev != 0) m_phase = PH_FIN;
`ifdef LOADER_TIMEOUT_EN
          else if (m_run >= TMO) begin m_err = 1; m_phase = PH_FIN; end
`endif
        end
        PH_FIN: if (!go) m_phase = PH_IDLE;
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  int wlog[$];
  always @(negedge clk) begin
    chk("in_ready",   in_ready,   m_phase == PH_LOAD);
    chk("imem_we",    imem_we,    m_we);
    chk("imem_addr",  imem_addr,  m_addr);
    chk("imem_wdata", imem_wdata, m_wdata);
    chk("cpu_start",  cpu_start,  m_phase != PH_RUN);
    chk("busy",       busy,       (m_phase >= PH_LOAD) && (m_phase <= PH_RUN));
    chk("finished",   finished,   m_phase == PH_FIN);
    chk("err",        err,        m_err);
    chk("word_count", word_count, m_wc);
    chk("run_cycles", run_cycles, m_run);
    if (imem_we) wlog.push_back(int'(imem_addr) * 512 + int'(imem_wdata));
  end

  logic [8:0] prog [0:15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer n words; go is scrambled meanwhile since LOAD must ignore it.
  task automatic send_prog(input int n, input bit with_last, input bit alt, input int dens);
    int   idx = 0;
    int   budget = 300;
    bit   tog = 1'b1;
    logic rdy;
    while (idx < n && budget > 0) begin
      in_valid = alt ? tog : (int'($urandom_range(99)) < dens);
      tog      = ~tog;
      in_data  = prog[idx];
      in_last  = with_last && (idx == n - 1);
      go       = 1'($urandom_range(1));
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && rdy) idx++;
      budget--;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    go       = 1'b1;
    chk("send_words_accepted", idx, n);
  endtask

  // Full load + run; cpu_done raised `delay` cycles after RUN cycle 1.
  task automatic run_prog(input int n, input bit alt, input int dens, input bit pre_done,
                          input int delay, output int launch_cyc, output int rc);
    int b;
    go = 1'b1;
    tick();
    send_prog(n, 1'b1, alt, dens);
    if (pre_done) cpu_done = 1'b1;
    b = 0;
    while (b < 20) begin
      @(negedge clk);
      if (!cpu_start) break;
      b++;
    end
    chk("launch_released", b < 20, 1);
    launch_cyc = b;
    repeat (delay) tick();
    cpu_done = 1'b1;
    b = 0;
    while (!finished && b < 200) begin
      tick();
      b++;
    end
    chk("fin_reached", finished, 1);
    rc = int'(run_cycles);
    cpu_done = 1'b0;
    go = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int lc, rc, n, b;
    int exp_run, exp_err;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle with go low: stray in_valid must do nothing.
    repeat (10) begin
      in_valid = 1'($urandom_range(1));
      in_data  = 9'($urandom);
      tick();
    end
    in_valid = 1'b0;
    chk("idle_cpu_start", cpu_start, 1);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_no_writes", wlog.size(), 0);

    // Directed five-word program, in_valid every other cycle.
    prog[0] = 9'h1A0; prog[1] = 9'h041; prog[2] = 9'h0C3; prog[3] = 9'h1FF; prog[4] = 9'h007;
    wlog.delete();
    run_prog(5, 1'b1, 0, 1'b0, 35, lc, rc);
`ifdef LOADER_TIMEOUT_EN
    exp_run = 20; exp_err = 1;
`else
    exp_run = 37; exp_err = 0;
`endif
    chk("dir_write_count", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      chk("dir_write_entry", wlog[i], i * 512 + int'(prog[i]));
    chk("dir_word_count", word_count, 5);
    chk("dir_launch_cycles", lc, 2);
    chk("dir_run_cycles", rc, exp_run);
    chk("dir_err", err, exp_err);
    chk("dir_back_to_idle", finished, 0);

    // Randomised programs, including single-word and memory-filling ones.
    for (int it = 0; it < 12; it++) begin
      n = (it == 0) ? 1 : (it == 1) ? DEPTH : int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) prog[i] = 9'($urandom);
      run_prog(n, 1'b0, int'($urandom_range(30, 100)), ($urandom_range(3) == 0),
               int'($urandom_range(0, 70)), lc, rc);
      chk("rnd_word_count", word_count, n);
    end

    // Overflow: DEPTH words without in_last.
    for (int i = 0; i < DEPTH; i++) prog[i] = 9'($urandom);
    go = 1'b1;
    tick();
    send_prog(DEPTH, 1'b0, 1'b0, 70);
    in_valid = 1'b1;
    tick();
    repeat (3) begin
      chk("ovf_no_ready", in_ready, 0);
      chk("ovf_no_write", imem_we, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("ovf_err", err, 1);
    chk("ovf_finished_held", finished, 1);
    chk("ovf_cpu_parked", cpu_start, 1);
    chk("ovf_word_count", word_count, DEPTH);
    go = 1'b0;
    tick();
    tick();

    // Asynchronous reset in the middle of a load.
    for (int i = 0; i < 4; i++) prog[i] = 9'($urandom);
    go = 1'b1;
    tick();
    send_prog(3, 1'b0, 1'b0, 100);
    #1 reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_cpu_start", cpu_start, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_word_count", word_count, 0);
    tick();
    tick();
    reset = 1'b0;
    wlog.delete();
    run_prog(4, 1'b0, 90, 1'b0, 3, lc, rc);
    chk("reload_first_addr", (wlog.size() > 0) ? wlog[0] / 512 : -1, 0);
    chk("reload_run_cycles", rc, 5);

    // CPU never reports done.
    prog[0] = 9'($urandom);
    go = 1'b1;
    tick();
    send_prog(1, 1'b1, 1'b0, 100);
    repeat (100) tick();
`ifdef LOADER_TIMEOUT_EN
    chk("hang_finished", finished, 1);
    chk("hang_err", err, 1);
    chk("hang_run_cycles", run_cycles, TMO);
`else
    chk("hang_busy", busy, 1);
    chk("hang_cpu_running", cpu_start, 0);
    chk("hang_run_cycles_sat", run_cycles, RUN_MAX);
`endif
    cpu_done = 1'b1;
    b = 0;
    while (!finished && b < 10) begin
      tick();
      b++;
    end
    chk("hang_fin_after_done", finished, 1);
    cpu_done = 1'b0;
    go = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
